// File: rtl/asi_arb.sv
// asi_arb: arbitrates the shared user-side memory port between the AXI slave
// write path and read path. A grant is held for a whole burst and alternates
// round-robin on ties. A granted owner that has not issued its first beat
// loses the grant after GNT_TIMEOUT contention cycles.
module asi_arb #(
    parameter int GNT_TIMEOUT = 16,
    parameter int FIRST_OWNER = 0
) (
    input  logic usr_clk,
    input  logic usr_reset,
    input  logic w_req,
    input  logic w_beat,
    input  logic w_last,
    input  logic r_req,
    input  logic r_beat,
    input  logic r_last,
    output logic wgranted,
    output logic rgranted,
    output logic arb_timeout,
    output logic arb_err
);

    localparam int CW = $clog2(GNT_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_THR = CW'(GNT_TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_SAT = CW'(GNT_TIMEOUT);
    localparam logic OWN_RST = (FIRST_OWNER == 0) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WGNT = 2'd1,
        RGNT = 2'd2
    } state_t;

    state_t          st, st_nxt, oth_st;
    logic            last_own;
    logic            started;
    logic [CW-1:0]   wait_cnt;
    logic            revoke;
    logic            own_beat, own_last, own_req, oth_req, contend;

    // Present the current owner's strobes in owner/other terms so WGNT and RGNT share one rule set
    always_comb begin
        own_beat = 1'b0;
        own_last = 1'b0;
        own_req  = 1'b0;
        oth_req  = 1'b0;
        oth_st   = IDLE;
        case (st)
            WGNT: begin
                own_beat = w_beat;
                own_last = w_last;
                own_req  = w_req;
                oth_req  = r_req;
                oth_st   = RGNT;
            end
            RGNT: begin
                own_beat = r_beat;
                own_last = r_last;
                own_req  = r_req;
                oth_req  = w_req;
                oth_st   = WGNT;
            end
            default: ;
        endcase
        contend = (st != IDLE) && !started && own_req && oth_req;
    end

    // State register
    always_ff @(posedge usr_clk) begin
        if (usr_reset) st <= IDLE;
        else           st <= st_nxt;
    end

    // Next-state: a beat always wins over revocation; revocation only before the first beat
    always_comb begin
        st_nxt = st;
        revoke = 1'b0;
        case (st)
            IDLE: begin
                if (w_req && r_req) st_nxt = last_own ? WGNT : RGNT;
                else if (w_req)     st_nxt = WGNT;
                else if (r_req)     st_nxt = RGNT;
            end
            WGNT, RGNT: begin
                if (own_beat) begin
                    if (own_last && oth_req) st_nxt = oth_st;
                end else if (!started && oth_req) begin
                    if (!own_req) begin
                        st_nxt = oth_st;
                    end else if (wait_cnt == CNT_THR) begin
                        st_nxt = oth_st;
                        revoke = 1'b1;
                    end
                end
            end
            default: st_nxt = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        wgranted = (st == WGNT);
        rgranted = (st == RGNT);
    end

    // Burst tracking, contention counter, round-robin memory and status flags
    always_ff @(posedge usr_clk) begin
        if (usr_reset) begin
            last_own    <= OWN_RST;
            started     <= 1'b0;
            wait_cnt    <= '0;
            arb_timeout <= 1'b0;
            arb_err     <= 1'b0;
        end else begin
            arb_timeout <= revoke;
            if ((w_beat && st != WGNT) || (r_beat && st != RGNT)) arb_err <= 1'b1;
            if (st_nxt != st) begin
                started  <= 1'b0;
                wait_cnt <= '0;
                if (st_nxt == WGNT)      last_own <= 1'b0;
                else if (st_nxt == RGNT) last_own <= 1'b1;
            end else if (own_beat) begin
                started  <= !own_last;
                wait_cnt <= '0;
            end else if (contend && wait_cnt != CNT_SAT) begin
                wait_cnt <= wait_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_asi_arb.sv
// tb_asi_arb: scoreboard bench for asi_arb. Each cycle the driver applies
// inputs and queues the outputs expected during that cycle; a monitor on the
// falling edge pops and compares them.
module tb_asi_arb;

    logic usr_clk = 1'b0;
    logic usr_reset, w_req, w_beat, w_last, r_req, r_beat, r_last;
    logic wgranted, rgranted, arb_timeout, arb_err;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    typedef struct {
        logic  ck;
        logic  ew, er, et, ee;
        string tag;
    } exp_t;

    exp_t sb[$];

    asi_arb #(.GNT_TIMEOUT(4), .FIRST_OWNER(0)) dut (
        .usr_clk     (usr_clk),
        .usr_reset   (usr_reset),
        .w_req       (w_req),
        .w_beat      (w_beat),
        .w_last      (w_last),
        .r_req       (r_req),
        .r_beat      (r_beat),
        .r_last      (r_last),
        .wgranted    (wgranted),
        .rgranted    (rgranted),
        .arb_timeout (arb_timeout),
        .arb_err     (arb_err)
    );

    always #5 usr_clk = ~usr_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply one cycle of inputs and queue the outputs expected during that cycle
    task automatic cyc(input logic rst, input logic wq, wb, wl, rq, rb, rl,
                       input logic ck, ew, er, et, ee, input string tag);
        exp_t e;
        @(posedge usr_clk);
        #2;
        usr_reset = rst;
        w_req = wq; w_beat = wb; w_last = wl;
        r_req = rq; r_beat = rb; r_last = rl;
        e.ck = ck; e.ew = ew; e.er = er; e.et = et; e.ee = ee; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        cyc(1, 0,0,0, 0,0,0, 0, 0,0,0,0, "rst");
    endtask

    // Compare queued expectations against the DUT mid-cycle
    always @(negedge usr_clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.ck) begin
                check({e.tag, ".wgnt"}, 32'(wgranted), 32'(e.ew));
                check({e.tag, ".rgnt"}, 32'(rgranted), 32'(e.er));
                check({e.tag, ".tout"}, 32'(arb_timeout), 32'(e.et));
                check({e.tag, ".err"},  32'(arb_err), 32'(e.ee));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        usr_reset = 1'b1;
        w_req = 0; w_beat = 0; w_last = 0; r_req = 0; r_beat = 0; r_last = 0;

        // Write only: grant at 3, burst 3..6, parked afterwards
        do_reset();
        cyc(0, 0,0,0, 0,0,0, 1, 0,0,0,0, "s1_reset");
        cyc(0, 1,0,0, 0,0,0, 1, 0,0,0,0, "s1_req");
        cyc(0, 1,1,0, 0,0,0, 1, 1,0,0,0, "s1_b0");
        cyc(0, 1,1,0, 0,0,0, 1, 1,0,0,0, "s1_b1");
        cyc(0, 1,1,0, 0,0,0, 1, 1,0,0,0, "s1_b2");
        cyc(0, 1,1,1, 0,0,0, 1, 1,0,0,0, "s1_last");
        cyc(0, 1,1,1, 0,0,0, 1, 1,0,0,0, "s1_b2b");
        cyc(0, 0,0,0, 0,0,0, 1, 1,0,0,0, "s1_park");
        cyc(0, 0,0,0, 0,0,0, 1, 1,0,0,0, "s1_park2");

        // Tie after reset: write first, then handover both ways
        do_reset();
        cyc(0, 0,0,0, 0,0,0, 1, 0,0,0,0, "s2_idle");
        cyc(0, 1,0,0, 1,0,0, 1, 0,0,0,0, "s2_tie");
        cyc(0, 1,1,1, 1,0,0, 1, 1,0,0,0, "s2_wlast");
        cyc(0, 1,0,0, 1,1,1, 1, 0,1,0,0, "s2_rlast");
        cyc(0, 0,0,0, 0,0,0, 1, 1,0,0,0, "s2_back");
        // Owner request drops before its first beat: immediate handover, no pulse
        cyc(0, 0,0,0, 1,0,0, 1, 1,0,0,0, "s2_drop");
        cyc(0, 0,0,0, 1,0,0, 1, 0,1,0,0, "s2_handr");
        cyc(0, 0,0,0, 0,0,0, 1, 0,1,0,0, "s2_parkr");

        // Timeout with GNT_TIMEOUT=4: grant for exactly 4 contention cycles
        do_reset();
        cyc(0, 1,0,0, 0,0,0, 1, 0,0,0,0, "s3_req");
        for (int i = 0; i < 4; i++)
            cyc(0, 1,0,0, 1,0,0, 1, 1,0,0,0, $sformatf("s3_hold%0d", i));
        cyc(0, 1,0,0, 1,0,0, 1, 0,1,1,0, "s3_revoke");
        cyc(0, 0,0,0, 1,0,0, 1, 0,1,0,0, "s3_pulse_end");
        cyc(0, 0,0,0, 0,0,0, 1, 0,1,0,0, "s3_parkr");

        // Beat at threshold wins; burst then cannot be interrupted
        do_reset();
        cyc(0, 1,0,0, 0,0,0, 1, 0,0,0,0, "s4_req");
        for (int i = 0; i < 3; i++)
            cyc(0, 1,0,0, 1,0,0, 1, 1,0,0,0, $sformatf("s4_hold%0d", i));
        cyc(0, 1,1,0, 1,0,0, 1, 1,0,0,0, "s4_beat_thr");
        for (int i = 0; i < 100; i++)
            cyc(0, 1,0,0, 1,0,0, 1, 1,0,0,0, "s4_nointr");

        // Read beat while write owns the port: sticky error, then reset mid-burst
        cyc(0, 1,0,0, 1,1,0, 1, 1,0,0,0, "s5_badbeat");
        cyc(0, 1,0,0, 1,0,0, 1, 1,0,0,1, "s5_err");
        cyc(0, 1,0,0, 1,0,0, 1, 1,0,0,1, "s5_sticky");
        cyc(1, 0,0,0, 0,0,0, 1, 1,0,0,1, "s5_inreset");
        cyc(0, 0,0,0, 0,0,0, 1, 0,0,0,0, "s5_after");
        // Only read requests from IDLE
        cyc(0, 0,0,0, 1,0,0, 1, 0,0,0,0, "s5_rreq");
        cyc(0, 0,0,0, 1,1,1, 1, 0,1,0,0, "s5_rgnt");

        @(posedge usr_clk);
        @(negedge usr_clk);
        #1;
        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
